// File: rtl/mmio_periph_pkg.sv
// mmio_periph_pkg
// Shared definitions for the memory-mapped peripheral bank:
//   - byte offsets of each register inside the 32-byte window
//   - bit positions inside TCON
//   - hex nibble to 7-segment (active-high, {dp,g..a}) decoder
package mmio_periph_pkg;

    localparam logic [4:0] OFF_TH      = 5'h00;
    localparam logic [4:0] OFF_TL      = 5'h04;
    localparam logic [4:0] OFF_TCON    = 5'h08;
    localparam logic [4:0] OFF_LEDS    = 5'h0C;
    localparam logic [4:0] OFF_DIGIT   = 5'h10;
    localparam logic [4:0] OFF_SYSTICK = 5'h14;

    localparam int TCON_EN  = 0;
    localparam int TCON_IEN = 1;
    localparam int TCON_IRQ = 2;

    // Segment order is {dp,g,f,e,d,c,b,a}; dp is always off.
    function automatic logic [7:0] hex_to_7seg(input logic [3:0] h);
        logic [7:0] seg;
        case (h)
            4'h0: seg = 8'h3F;
            4'h1: seg = 8'h06;
            4'h2: seg = 8'h5B;
            4'h3: seg = 8'h4F;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'h6D;
            4'h6: seg = 8'h7D;
            4'h7: seg = 8'h07;
            4'h8: seg = 8'h7F;
            4'h9: seg = 8'h6F;
            4'hA: seg = 8'h77;
            4'hB: seg = 8'h7C;
            4'hC: seg = 8'h39;
            4'hD: seg = 8'h5E;
            4'hE: seg = 8'h79;
            default: seg = 8'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/periph_timer.sv
// periph_timer
// Reloadable 32-bit up-counter with interrupt status.
//   clk, reset   : clock, synchronous active-high reset
//   th_we/tl_we/tcon_we : decoded software write strobes
//   wr_data      : store data
//   th, tl, tcon : current register values (for the read mux)
//   irq          : TCON irq status bit
// TL counts up while TCON.en=1; on 0xFFFFFFFF it reloads from TH and,
// if TCON.ien=1, sets TCON.irq. A software TL write in the overflow
// cycle wins over the reload, but the irq status is still raised. A
// software clear of TCON.irq in the overflow cycle loses to the set.
module periph_timer
    import mmio_periph_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        th_we,
    input  logic        tl_we,
    input  logic        tcon_we,
    input  logic [31:0] wr_data,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [2:0]  tcon,
    output logic        irq
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic        ovf;

    always_comb begin
        ovf  = tcon_q[TCON_EN] && (tl_q == 32'hFFFF_FFFF);

        th_d = th_we ? wr_data : th_q;

        tl_d = tl_q;
        if (tcon_q[TCON_EN]) begin
            tl_d = ovf ? th_q : tl_q + 32'd1;
        end
        if (tl_we) begin
            tl_d = wr_data;
        end

        tcon_d = tcon_we ? wr_data[2:0] : tcon_q;
        if (ovf && tcon_q[TCON_IEN]) begin
            tcon_d[TCON_IRQ] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
        end
    end

    assign th   = th_q;
    assign tl   = tl_q;
    assign tcon = tcon_q;
    assign irq  = tcon_q[TCON_IRQ];

endmodule

// File: rtl/mmio_periph_bank.sv
// mmio_periph_bank
// Memory-mapped peripheral bank for the MEM stage: timer, LEDs, 7-segment
// digit register and a free-running systick, in a 32-byte window at
// BASE_ADDR. Loads return one cycle later on rd_data with rd_hit=1.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   addr, rd_en, wr_en, wr_data : MEM-stage access (addr[1:0] ignored)
//   rd_data, rd_hit     : registered load result / window hit
//   irq                 : timer interrupt status
//   leds, digit, digit_en, systick : peripheral outputs
// Optional build macro MMIO_DIGIT_SCAN_EN: DIGIT holds NDIG hex nibbles
// plus a blank bit, and the hardware scans them onto digit/digit_en.
// Without it digit/digit_en are plain software-written registers.
module mmio_periph_bank
    import mmio_periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          LED_W     = 8,
    parameter int          NDIG      = 4,
    parameter int          SCAN_DIV  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic              rd_hit,
    output logic              irq,
    output logic [LED_W-1:0]  leds,
    output logic [7:0]        digit,
    output logic [NDIG-1:0]   digit_en,
    output logic [31:0]       systick
);

    logic        hit;
    logic [4:0]  off;
    logic        rd_acc, wr_acc;
    logic        dig_we;

    assign hit    = (addr[31:5] == BASE_ADDR[31:5]);
    assign off    = {addr[4:2], 2'b00};
    assign rd_acc = rd_en && hit;
    assign wr_acc = wr_en && hit;
    assign dig_we = wr_acc && (off == OFF_DIGIT);

    logic unused_addr;
    assign unused_addr = ^addr[1:0];

    // ---------------- timer ----------------
    logic [31:0] th, tl;
    logic [2:0]  tcon;

    periph_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .th_we   (wr_acc && (off == OFF_TH)),
        .tl_we   (wr_acc && (off == OFF_TL)),
        .tcon_we (wr_acc && (off == OFF_TCON)),
        .wr_data (wr_data),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .irq     (irq)
    );

    // ---------------- systick, LEDs ----------------
    logic [31:0]      systick_q, systick_d;
    logic [LED_W-1:0] leds_q, leds_d;

    always_comb begin
        systick_d = systick_q + 32'd1;
        leds_d    = leds_q;
        if (wr_acc && (off == OFF_LEDS)) begin
            leds_d = wr_data[LED_W-1:0];
        end
    end

    // ---------------- digit register / scan ----------------
    logic [7:0]      digit_q, digit_d;
    logic [NDIG-1:0] digit_en_q, digit_en_d;
    logic [31:0]     digit_rd;

`ifdef MMIO_DIGIT_SCAN_EN
    localparam int DW = 4 * NDIG + 1;
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PS_TC = PW'(SCAN_DIV - 1);

    logic [DW-1:0]   dig_store_q, dig_store_d;
    logic [PW-1:0]   ps_q, ps_d;
    logic [NDIG-1:0] ptr_q, ptr_d;
    logic            ps_tc;
    logic [3:0]      nib_masked [NDIG];
    logic [3:0]      nib_sel;

    // One-hot pointer gates each nibble; OR-reduce gives the selected one.
    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_nib
            assign nib_masked[gi] = ptr_q[gi] ? dig_store_q[4*gi +: 4] : 4'h0;
        end
    endgenerate

    always_comb begin
        nib_sel = 4'h0;
        for (int i = 0; i < NDIG; i++) begin
            nib_sel = nib_sel | nib_masked[i];
        end
    end

    always_comb begin
        dig_store_d = dig_we ? DW'(wr_data) : dig_store_q;
        ps_tc       = (ps_q == PS_TC);
        ps_d        = ps_tc ? '0 : ps_q + 1'b1;
        // Rotate left by one; for NDIG=1 this degenerates to holding.
        ptr_d       = ps_tc ? ((ptr_q << 1) | (ptr_q >> (NDIG - 1))) : ptr_q;
        // Outputs are registered from the current pointer, so they follow
        // a pointer change by one cycle.
        digit_en_d  = dig_store_q[DW-1] ? '0 : ptr_q;
        digit_d     = hex_to_7seg(nib_sel);
        digit_rd    = 32'(dig_store_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dig_store_q <= '0;
            ps_q        <= '0;
            ptr_q       <= NDIG'(1);
            digit_q     <= '0;
            digit_en_q  <= '0;
        end else begin
            dig_store_q <= dig_store_d;
            ps_q        <= ps_d;
            ptr_q       <= ptr_d;
            digit_q     <= digit_d;
            digit_en_q  <= digit_en_d;
        end
    end
`else
    logic unused_scan_cfg;
    assign unused_scan_cfg = (SCAN_DIV >= 2);

    always_comb begin
        digit_d    = digit_q;
        digit_en_d = digit_en_q;
        if (dig_we) begin
            digit_d    = wr_data[7:0];
            digit_en_d = wr_data[8 +: NDIG];
        end
        digit_rd             = '0;
        digit_rd[7:0]        = digit_q;
        digit_rd[8 +: NDIG]  = digit_en_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q    <= '0;
            digit_en_q <= '0;
        end else begin
            digit_q    <= digit_d;
            digit_en_q <= digit_en_d;
        end
    end
`endif

    // ---------------- read port ----------------
    // Mux samples the pre-edge register values, so a same-cycle write is
    // not visible to the read (read-before-write).
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_hit_q, rd_hit_d;

    always_comb begin
        rd_data_d = '0;
        rd_hit_d  = rd_acc;
        if (rd_acc) begin
            case (off)
                OFF_TH:      rd_data_d = th;
                OFF_TL:      rd_data_d = tl;
                OFF_TCON:    rd_data_d[2:0] = tcon;
                OFF_LEDS:    rd_data_d[LED_W-1:0] = leds_q;
                OFF_DIGIT:   rd_data_d = digit_rd;
                OFF_SYSTICK: rd_data_d = systick_q;
                default:     rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            systick_q <= '0;
            leds_q    <= '0;
            rd_data_q <= '0;
            rd_hit_q  <= 1'b0;
        end else begin
            systick_q <= systick_d;
            leds_q    <= leds_d;
            rd_data_q <= rd_data_d;
            rd_hit_q  <= rd_hit_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_hit   = rd_hit_q;
    assign leds     = leds_q;
    assign digit    = digit_q;
    assign digit_en = digit_en_q;
    assign systick  = systick_q;

endmodule
